// File: rtl/sequenciador_soma.sv
// Nibble-serial add/subtract controller.
// One 4-bit ripple adder is reused across NIBBLES cycles per operation.
module somador (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module sequenciador_soma #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nx;
  logic          cy;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_s;
  logic          nib_co;

  assign nib_a = opa[{idx, 2'b00} +: 4];
  assign nib_b = opb[{idx, 2'b00} +: 4];

  somador u_somador (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cy),
    .s    (nib_s),
    .cout (nib_co)
  );

  // Work word as it will look once the current slice lands.
  always_comb begin
    work_nx = work;
    work_nx[{idx, 2'b00} +: 4] = nib_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      opa      <= '0;
      opb      <= '0;
      work     <= '0;
      cy       <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= op ? ~b : b;
            cy    <= op;
            idx   <= '0;
            state <= S_CALC;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_CALC: begin
          work <= work_nx;
          cy   <= nib_co;
          idx  <= idx + IW'(1);
          if (idx == LAST) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= work_nx;
            carry    <= nib_co;
            overflow <= (opa[W-1] == opb[W-1]) &&
                        (work_nx[W-1] != opa[W-1]);
            zero     <= (work_nx == '0);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_soma.sv
// Bench for sequenciador_soma: directed, random, hazard and reset scenarios
// against an integer-arithmetic reference model.
module tb_sequenciador_soma;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_res = '0;

  sequenciador_soma #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic o, input logic [W-1:0] x,
                                input logic [W-1:0] y,
                                output logic [W-1:0] r,
                                output logic [2:0] f);
    int ux, uy, sx, sy, se, ue;
    logic c, v, z;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o) begin
      ue = ux - uy;
      se = sx - sy;
      c  = (ux >= uy);
    end else begin
      ue = ux + uy;
      se = sx + sy;
      c  = (ue > 65535);
    end
    r = W'(ue);
    v = (se > 32767) || (se < -32768);
    z = (r == '0);
    f = {c, v, z};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    total++;
    if ({ready, busy, done, carry, overflow, zero} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=100000",
               {ready, busy, done, carry, overflow, zero});
    end
    total++;
    if (result !== '0) begin
      bad++;
      $display("FAIL reset_result got=%h want=0000", result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release ready=%b busy=%b want 1/0", ready, busy);
    end
    exp_res = '0;
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [2:0]   f;
    model(o, x, y, r, f);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
    for (int k = 0; k < N; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
        bad++;
        $display("FAIL op_busy k=%0d got b/d/r=%b%b%b want 100",
                 k, busy, done, ready);
      end
      total++;
      if (result !== exp_res) begin
        bad++;
        $display("FAIL op_hold k=%0d got=%h want=%h", k, result, exp_res);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL op_done got d/b/r=%b%b%b want 100", done, busy, ready);
    end
    total++;
    if (result !== r) begin
      bad++;
      $display("FAIL op_result %h %s %h got=%h want=%h",
               x, o ? "-" : "+", y, result, r);
    end
    total++;
    if ({carry, overflow, zero} !== f) begin
      bad++;
      $display("FAIL op_flags %h %s %h got cvz=%b want=%b",
               x, o ? "-" : "+", y, {carry, overflow, zero}, f);
    end
    exp_res = r;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || ready !== 1'b1 || result !== r) begin
      bad++;
      $display("FAIL op_after got d/r=%b%b res=%h want 01 %h",
               done, ready, result, r);
    end
  endtask

  task automatic test_directed;
    logic         to [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b1};
    logic [W-1:0] ta [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005,
                             16'h8000, 16'h1234, 16'h8000, 16'h0000};
    logic [W-1:0] tb [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007,
                             16'h0001, 16'h1234, 16'h8000, 16'h0000};
    for (int i = 0; i < 8; i++) run_op(to[i], ta[i], tb[i]);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      run_op(1'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic test_ignore;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h0001;
    b     = 16'h0002;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      total++;
      if (busy !== 1'b1 || result !== exp_res) begin
        bad++;
        $display("FAIL ign_busy k=%0d busy=%b res=%h want 1 %h",
                 k, busy, result, exp_res);
      end
      start = (k == 1);
      op    = 1'b1;
      a     = 16'hAAAA;
      b     = 16'h5555;
      @(posedge clk);
      #1;
    end
    total++;
    if (done !== 1'b1 || result !== 16'h0003) begin
      bad++;
      $display("FAIL ign_done done=%b res=%h want 1 0003", done, result);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_res = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1 ||
          result !== 16'h0003) begin
        bad++;
        $display("FAIL ign_after k=%0d b/d/r=%b%b%b res=%h want 001 0003",
                 k, busy, done, ready, result);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] qr [$];
    logic [2:0]   qf [$];
    int           qt [$];
    int           last_acc = -1;
    logic         prev_done = 1'b0;
    logic [W-1:0] r;
    logic [2:0]   f;
    logic [W-1:0] x, y;
    logic         o;
    int           t;
    start = 1'b1;
    for (int cyc = 0; cyc < 34; cyc++) begin
      if (cyc >= 26) start = 1'b0;
      if (start && ready) begin
        x = W'($urandom);
        y = W'($urandom);
        o = 1'($urandom);
        a = x;
        b = y;
        op = o;
        model(o, x, y, r, f);
        qr.push_back(r);
        qf.push_back(f);
        qt.push_back(cyc);
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != N + 2) begin
            bad++;
            $display("FAIL b2b_interval got=%0d want=%0d",
                     cyc - last_acc, N + 2);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        total++;
        if (prev_done) begin
          bad++;
          $display("FAIL b2b_merge cyc=%0d done high twice", cyc);
        end
        total++;
        if (qr.size() == 0) begin
          bad++;
          $display("FAIL b2b_spurious cyc=%0d got done want none", cyc);
        end else begin
          r = qr.pop_front();
          f = qf.pop_front();
          t = qt.pop_front();
          total++;
          if (cyc - t != N) begin
            bad++;
            $display("FAIL b2b_latency got=%0d want=%0d", cyc - t, N);
          end
          total++;
          if (result !== r || {carry, overflow, zero} !== f) begin
            bad++;
            $display("FAIL b2b_result got=%h/%b want=%h/%b",
                     result, {carry, overflow, zero}, r, f);
          end
          exp_res = r;
        end
      end
      prev_done = done;
    end
    total++;
    if (qr.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing got %0d pending want 0", qr.size());
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready, busy, done, carry, overflow, zero} !== 6'b100000 ||
        result !== '0) begin
      bad++;
      $display("FAIL rstmid_clear got=%b res=%h want=100000 0000",
               {ready, busy, done, carry, overflow, zero}, result);
    end
    exp_res = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_hold k=%0d done=%b busy=%b want 0 0",
                 k, done, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_idle k=%0d d/b/r=%b%b%b want 001",
                 k, done, busy, ready);
      end
    end
    run_op(1'b0, 16'h0F0F, 16'h00F1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequenciador_soma.md
Name: sequenciador_soma

Overview:
- Nibble-serial multi-word add/subtract controller.
- Holds exactly one 4-bit ripple adder instance (somador) and time-shares it over NIBBLES cycles to add or subtract operands of 4*NIBBLES bits.
- Provides a ready/start handshake, a one-cycle done pulse, a registered result and ALU flags (carry, overflow, zero).
- Sits between the ULA operand registers and the flag/result register file.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand. W = 4*NIBBLES is derived internally and is not overridable. Legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- op  in  1  0 = add (a+b), 1 = subtract (a-b).
- a  in  W  operand A, sampled on accept.
- b  in  W  operand B, sampled on accept.
- ready  out  1  high in IDLE only.
- busy  out  1  high while slices are being computed (CALC).
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  W  registered sum/difference.
- carry  out  1  carry out of the MSB slice. For subtract, 1 means no borrow (a >= b unsigned).
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (async assert, rst_n=0):
  - State goes to IDLE and slice index to 0.
  - Outputs: ready=1, busy=0, done=0, result=0, carry=0, overflow=0, zero=0.
  - Any operation in flight is discarded.
  - Release is synchronous to clk.
- State machine IDLE -> CALC -> DONE -> IDLE:
  - IDLE: ready=1. On a clock edge with start=1:
    - opA <= a
    - opB <= op ? ~b : b
    - carry register <= op
    - idx <= 0
    - go to CALC.
    - With start=0, stay in IDLE.
  - CALC: busy=1, ready=0. Each cycle:
    - The adder receives opA[4*idx+:4], opB[4*idx+:4] and the carry register.
    - The sum nibble is written into work[4*idx+:4]; the carry register takes cout.
    - idx increments.
    - When idx == NIBBLES-1, the next state is DONE. CALC lasts exactly NIBBLES cycles.
  - DONE (one cycle): done=1, busy=0, ready=0. On entry, commit:
    - result <= work
    - carry <= final cout
    - overflow <= (opA[W-1] == opB[W-1]) && (work[W-1] != opA[W-1]), using the already-inverted opB for subtract
    - zero <= (work == 0)
    - The next state is unconditionally IDLE.
- Latency: start accepted on edge T. busy is high for cycles T+1..T+NIBBLES. done is high in cycle T+NIBBLES+1. ready returns in cycle T+NIBBLES+2.
- Minimum issue interval is NIBBLES+2 cycles.
- result and flags hold their previous values throughout CALC. They update only at DONE entry and hold until the next DONE or reset.
- start while busy or in DONE is ignored. No queuing, no effect on the running operation.
- a, b and op may change freely after accept; only the sampled copies are used.
- Arithmetic is modulo 2^W with no saturation. Exactly one somador instance; no other adder performs the slice sum.
- Reset asserted during CALC or DONE:
  - No done pulse is produced for the aborted operation.
  - result and flags clear to 0.
  - After release, the block is in IDLE and accepts a new start.

Test Plan (NIBBLES=4):
- add 0x1234+0x4321 -> result=0x5555, carry=0, overflow=0, zero=0. done exactly 5 cycles after the accept edge; busy high for 4 cycles.
- add 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1, overflow=0. add 0x7FFF+0x0001 -> 0x8000, carry=0, overflow=1.
- sub 0x0005-0x0007 -> 0xFFFE, carry=0, overflow=0. sub 0x8000-0x0001 -> 0x7FFF, carry=1, overflow=1. sub 0x1234-0x1234 -> 0x0000, carry=1, zero=1.
- Accept add 0x0001+0x0002, then pulse start with op=1, a=0xAAAA, b=0x5555 during busy and again during done -> both ignored, result=0x0003. result stays at its previous value throughout busy.
- Back-to-back: hold start=1 continuously -> a new operation is accepted every 6 cycles. done pulses are exactly one cycle wide and never merge.
- Assert rst_n=0 in the 2nd CALC cycle of 0xFFFF+0xFFFF -> all outputs clear immediately and no done pulse. After release, add 0x0F0F+0x00F1 -> 0x1000, carry=0, overflow=0.
